// File: rtl/decode_stage_if.sv
// Fetch-side and issue-side handshake bundle for decode_stage.
interface decode_stage_if #(parameter int ADDR_W = 16);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [15:0]       in_instr;
  logic [ADDR_W-1:0] in_pc;
  logic [1:0]        mode;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_pc;
  logic              out_we, out_p1_sel, out_mem_re, out_mem_we, out_jump, out_bad;
  logic [3:0]        out_dst, out_p0, out_p1;
  logic [2:0]        out_alu_op;
  logic [7:0]        out_imm;
  logic [2:0]        out_cond;
  logic [ADDR_W-1:0] out_target;
  logic [ADDR_W-1:0] out_link;

  modport master (
    output flush, in_valid, in_instr, in_pc, mode, out_ready,
    input  in_ready, out_valid, out_pc, out_we, out_p1_sel, out_mem_re, out_mem_we,
           out_jump, out_bad, out_dst, out_p0, out_p1, out_alu_op, out_imm, out_cond,
           out_target, out_link
  );

  modport slave (
    input  flush, in_valid, in_instr, in_pc, mode, out_ready,
    output in_ready, out_valid, out_pc, out_we, out_p1_sel, out_mem_re, out_mem_we,
           out_jump, out_bad, out_dst, out_p0, out_p1, out_alu_op, out_imm, out_cond,
           out_target, out_link
  );
endinterface

// File: rtl/decode_stage.sv
// Decode stage: input FIFO, LI expansion into LHIGH/LLOW, registered micro-op output.
// Optional user-mode register/opcode check enabled by defining DECODE_PRIV_CHECK_EN.
module decode_stage #(
  parameter int ADDR_W   = 16,
  parameter int DEPTH    = 4,
  parameter int LINK_REG = 12
) (
  input logic           clk,
  input logic           rst,
  decode_stage_if.slave io
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic              we, p1_sel, mem_re, mem_we, jump, bad;
    logic [3:0]        dst, p0, p1;
    logic [2:0]        alu_op;
    logic [7:0]        imm;
    logic [2:0]        cond;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] link;
  } uop_t;

  typedef enum logic {NORM, LI_LO} state_t;

  logic [15:0]       instr_q [DEPTH];
  logic [ADDR_W-1:0] pc_q    [DEPTH];
  logic [PW-1:0]     rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]     cnt_q, pop_n;
  state_t            state_q, state_d;
  logic [3:0]        li_rd_q;
  logic [7:0]        li_imm_q;
  logic [ADDR_W-1:0] li_pc_q;
  uop_t              uop_q, uop_d;
  logic              uop_valid_q;
  logic              push, load, issue;
  logic [15:0]       head_w, nxt_w, dec_w;

  // kind 0: plain instruction, 1: LHIGH half of LI, 2: LLOW half of LI
  function automatic uop_t decode(input logic [15:0] w, input logic [ADDR_W-1:0] pc,
                                  input logic [1:0] kind, input logic [7:0] li_imm);
    uop_t u;
    u        = '0;
    u.pc     = pc;
    u.imm    = w[7:0];
    u.cond   = 3'd7;
    u.link   = pc + ADDR_W'(1);
    if (kind != 2'd0) begin
      u.alu_op = (kind == 2'd1) ? 3'd7 : 3'd6;
      u.dst    = w[11:8];
      u.p0     = w[11:8];
      u.p1_sel = 1'b1;
      u.we     = |w[11:8];
      u.imm    = li_imm;
    end else begin
      case (w[15:12])
        4'h0, 4'h1, 4'h2: begin
          u.alu_op = w[14:12];
          u.p0 = w[7:4]; u.p1 = w[3:0]; u.dst = w[11:8]; u.we = |w[11:8];
        end
        4'h3: begin
          u.p0 = w[7:4]; u.dst = w[11:8]; u.mem_re = 1'b1; u.we = |w[11:8];
        end
        4'h4: begin
          u.p0 = w[7:4]; u.p1 = w[11:8]; u.mem_we = 1'b1;
        end
        4'h5, 4'h6, 4'h7: begin
          u.dst = w[11:8]; u.p0 = w[11:8]; u.p1_sel = 1'b1; u.we = |w[11:8];
          if (w[15:12] == 4'h5)      u.alu_op = 3'd7;
          else if (w[15:12] == 4'h6) u.alu_op = 3'd6;
          else begin
            u.alu_op = (w[5:4] == 2'd0) ? 3'd3 : (w[5:4] == 2'd1) ? 3'd4 : 3'd5;
            u.imm    = {4'h0, w[3:0]};
          end
        end
        4'h8: begin
          u.cond   = w[11:9];
          u.jump   = &w[11:9];
          u.target = pc + {{(ADDR_W-9){w[8]}}, w[8:0]};
        end
        4'h9: begin
          u.jump = 1'b1; u.dst = 4'(LINK_REG); u.we = 1'b1;
          u.target = pc + {{(ADDR_W-12){w[11]}}, w[11:0]};
        end
        4'hA: begin
          u.jump = 1'b1; u.p0 = w[11:8];
        end
        default: ;
      endcase
    end
    return u;
  endfunction

  assign io.in_ready = (cnt_q != CW'(DEPTH));
  assign push   = io.in_valid && io.in_ready && !io.flush;
  assign load   = !uop_valid_q || io.out_ready;
  assign head_w = instr_q[rd_ptr_q];
  assign nxt_w  = instr_q[rd_ptr_q + PW'(1)];

  always_comb begin
    issue   = 1'b0;
    pop_n   = '0;
    state_d = state_q;
    dec_w   = head_w;
    uop_d   = decode(head_w, pc_q[rd_ptr_q], 2'd0, 8'h00);
    case (state_q)
      NORM: begin
        if (head_w[15:12] == 4'hF) begin
          uop_d = decode(head_w, pc_q[rd_ptr_q], 2'd1, nxt_w[15:8]);
          if (load && cnt_q >= CW'(2)) begin
            issue = 1'b1; pop_n = CW'(2); state_d = LI_LO;
          end
        end else if (load && cnt_q != '0) begin
          issue = 1'b1; pop_n = CW'(1);
        end
      end
      LI_LO: begin
        dec_w = {4'hF, li_rd_q, 8'h00};
        uop_d = decode(dec_w, li_pc_q, 2'd2, li_imm_q);
        if (load) begin
          issue = 1'b1; state_d = NORM;
        end
      end
      default: state_d = NORM;
    endcase
`ifdef DECODE_PRIV_CHECK_EN
    uop_d.bad = (io.mode == 2'b01) &&
                (uop_d.dst > 4'd12 || uop_d.p0 > 4'd12 || uop_d.p1 > 4'd12 ||
                 dec_w[15:12] == 4'hE);
`else
    uop_d.bad = 1'b0;
`endif
  end

`ifndef DECODE_PRIV_CHECK_EN
  logic unused_mode;
  assign unused_mode = ^io.mode;
`endif

  // FIFO storage is not reset; occupancy is tracked by cnt_q alone.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_q[wr_ptr_q] <= io.in_instr;
      pc_q[wr_ptr_q]    <= io.in_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      cnt_q       <= '0;
      state_q     <= NORM;
      li_rd_q     <= '0;
      li_imm_q    <= '0;
      li_pc_q     <= '0;
      uop_q       <= '0;
      uop_valid_q <= 1'b0;
    end else if (io.flush) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      cnt_q       <= '0;
      state_q     <= NORM;
      uop_valid_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_q + PW'(push);
      rd_ptr_q <= rd_ptr_q + pop_n[PW-1:0];
      cnt_q    <= cnt_q + CW'(push) - pop_n;
      state_q  <= state_d;
      if (state_q == NORM && pop_n == CW'(2)) begin
        li_rd_q  <= head_w[11:8];
        li_imm_q <= nxt_w[7:0];
        li_pc_q  <= pc_q[rd_ptr_q];
      end
      if (issue) begin
        uop_q       <= uop_d;
        uop_valid_q <= 1'b1;
      end else if (load) begin
        uop_valid_q <= 1'b0;
      end
    end
  end

  assign io.out_valid  = uop_valid_q;
  assign io.out_pc     = uop_q.pc;
  assign io.out_we     = uop_q.we;
  assign io.out_p1_sel = uop_q.p1_sel;
  assign io.out_mem_re = uop_q.mem_re;
  assign io.out_mem_we = uop_q.mem_we;
  assign io.out_jump   = uop_q.jump;
  assign io.out_bad    = uop_q.bad;
  assign io.out_dst    = uop_q.dst;
  assign io.out_p0     = uop_q.p0;
  assign io.out_p1     = uop_q.p1;
  assign io.out_alu_op = uop_q.alu_op;
  assign io.out_imm    = uop_q.imm;
  assign io.out_cond   = uop_q.cond;
  assign io.out_target = uop_q.target;
  assign io.out_link   = uop_q.link;
endmodule

// File: tb/tb_decode_stage.sv
// Randomized and directed bench for decode_stage against a queue-based micro-op model.
module tb_decode_stage;
  localparam int AW    = 16;
  localparam int DEPTH = 4;
`ifdef DECODE_PRIV_CHECK_EN
  localparam bit PRIV = 1'b1;
`else
  localparam bit PRIV = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decode_stage_if #(.ADDR_W(AW)) ifc();
  decode_stage #(.ADDR_W(AW), .DEPTH(DEPTH), .LINK_REG(12)) dut (.clk(clk), .rst(rst), .io(ifc));

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [79:0] expq[$];
  bit          li_pend = 1'b0;
  logic [15:0] li_w, li_pc;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // kind 0: plain word, 1: LHIGH of an LI, 2: LLOW of an LI (ib = immediate byte)
  function automatic logic [79:0] ref_uop(input logic [15:0] w, input logic [15:0] pc,
                                          input int kind, input logic [7:0] ib, input logic [1:0] md);
    int op = int'(w[15:12]);
    int rd = int'(w[11:8]);
    int rs = int'(w[7:4]);
    int rt = int'(w[3:0]);
    int dst = 0, p0 = 0, p1 = 0, alu = 0, imm = int'(w[7:0]), cond = 7, tgt = 0, off;
    bit we = 0, p1s = 0, mre = 0, mwe = 0, jmp = 0, bad;
    if (kind != 0) begin
      alu = (kind == 1) ? 7 : 6;
      dst = rd; p0 = rd; p1s = 1; we = (rd != 0); imm = int'(ib);
    end else if (op <= 2) begin
      alu = op; p0 = rs; p1 = rt; dst = rd; we = (rd != 0);
    end else if (op == 3) begin
      p0 = rs; dst = rd; mre = 1; we = (rd != 0);
    end else if (op == 4) begin
      p0 = rs; p1 = rd; mwe = 1;
    end else if (op >= 5 && op <= 7) begin
      p0 = rd; dst = rd; p1s = 1; we = (rd != 0);
      if (op == 5) alu = 7;
      else if (op == 6) alu = 6;
      else begin
        alu = (rs % 4 == 0) ? 3 : (rs % 4 == 1) ? 4 : 5;
        imm = rt;
      end
    end else if (op == 8) begin
      cond = rd / 2;
      off  = int'(w[8:0]);
      if (off >= 256) off -= 512;
      tgt = (int'(pc) + off + 65536) % 65536;
      jmp = (cond == 7);
    end else if (op == 9) begin
      off = int'(w[11:0]);
      if (off >= 2048) off -= 4096;
      tgt = (int'(pc) + off + 65536) % 65536;
      jmp = 1; dst = 12; we = 1;
    end else if (op == 10) begin
      jmp = 1; p0 = rd;
    end
    bad = PRIV && (md == 2'b01) && (dst > 12 || p0 > 12 || p1 > 12 || (kind == 0 && op == 14));
    return {pc, we, p1s, mre, mwe, jmp, bad, 4'(dst), 4'(p0), 4'(p1), 3'(alu), 8'(imm),
            3'(cond), 16'(tgt), 16'((int'(pc) + 1) % 65536)};
  endfunction

  function automatic logic [79:0] obs_uop();
    return {ifc.out_pc, ifc.out_we, ifc.out_p1_sel, ifc.out_mem_re, ifc.out_mem_we, ifc.out_jump,
            ifc.out_bad, ifc.out_dst, ifc.out_p0, ifc.out_p1, ifc.out_alu_op, ifc.out_imm,
            ifc.out_cond, ifc.out_target, ifc.out_link};
  endfunction

  task automatic model_push(input logic [15:0] w, input logic [15:0] pc);
    if (li_pend) begin
      li_pend = 1'b0;
      expq.push_back(ref_uop(li_w, li_pc, 1, w[15:8], ifc.mode));
      expq.push_back(ref_uop(li_w, li_pc, 2, w[7:0], ifc.mode));
    end else if (w[15:12] == 4'hF) begin
      li_pend = 1'b1; li_w = w; li_pc = pc;
    end else begin
      expq.push_back(ref_uop(w, pc, 0, 8'h00, ifc.mode));
    end
  endtask

  // One clock: observe on the falling edge, advance the model, then step past the rising edge.
  task automatic cyc();
    @(negedge clk);
    if (ifc.out_valid) begin
      if (expq.size() == 0) chk("spurious_valid", 80'd1, 80'd0);
      else begin
        chk("uop", obs_uop(), expq[0]);
        if (ifc.out_ready) void'(expq.pop_front());
      end
    end
    if (ifc.flush) begin
      expq.delete();
      li_pend = 1'b0;
    end else if (ifc.in_valid && ifc.in_ready) begin
      model_push(ifc.in_instr, ifc.in_pc);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] w, input logic [15:0] pc);
    ifc.in_valid = 1'b1; ifc.in_instr = w; ifc.in_pc = pc;
    cyc();
    ifc.in_valid = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    ifc.in_valid = 1'b0; ifc.out_ready = 1'b1;
    while ((expq.size() != 0 || ifc.out_valid) && k < 40) begin
      cyc();
      k++;
    end
    chk("drain_left", 80'(expq.size()), 80'd0);
  endtask

  task automatic priv_case(input logic [1:0] md, input logic [15:0] w, input logic [15:0] pc, input bit exp_bad);
    ifc.mode = md;
    push(w, pc);
    cyc();
    chk("bad_bit", 80'(ifc.out_bad), 80'(exp_bad));
    drain();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int acc;
    logic [15:0] w;
    rst = 1'b1;
    ifc.flush = 1'b0; ifc.in_valid = 1'b0; ifc.in_instr = '0; ifc.in_pc = '0;
    ifc.mode = 2'b00; ifc.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 80'(ifc.out_valid), 80'd0);
    chk("rst_ready", 80'(ifc.in_ready), 80'd1);
    chk("rst_outs", obs_uop(), 80'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // ADD-family word and first-issue latency
    push(16'h1123, 16'h0010);
    chk("lat_early", 80'(ifc.out_valid), 80'd0);
    cyc();
    chk("lat_valid", 80'(ifc.out_valid), 80'd1);
    chk("sub_alu", 80'(ifc.out_alu_op), 80'd1);
    chk("sub_pc", 80'(ifc.out_pc), 80'h0010);
    drain();

    // branches: always-taken backwards, then conditional
    push(16'h8FFE, 16'h0020);
    cyc();
    chk("br_target", 80'(ifc.out_target), 80'h001E);
    chk("br_jump", 80'(ifc.out_jump), 80'd1);
    push(16'h8300, 16'h0021);
    cyc();
    chk("br_cond", 80'({ifc.out_jump, ifc.out_cond}), 80'({1'b0, 3'd1}));
    drain();

    // LI expansion
    push(16'hF500, 16'h0030);
    push(16'hABCD, 16'h0031);
    cyc();
    chk("li_hi", 80'({ifc.out_alu_op, ifc.out_dst, ifc.out_imm, ifc.out_pc}), 80'({3'd7, 4'd5, 8'hAB, 16'h0030}));
    cyc();
    chk("li_lo", 80'({ifc.out_alu_op, ifc.out_dst, ifc.out_imm, ifc.out_pc}), 80'({3'd6, 4'd5, 8'hCD, 16'h0030}));
    drain();

    // back-pressure: output register plus DEPTH FIFO entries fill up
    ifc.out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      w = 16'($urandom);
      if (w[15:12] == 4'hF) w[15] = 1'b0;
      ifc.in_valid = 1'b1; ifc.in_instr = w; ifc.in_pc = 16'(16'h0040 + i);
      if (ifc.in_ready) acc++;
      cyc();
    end
    ifc.in_valid = 1'b0;
    chk("full_ready", 80'(ifc.in_ready), 80'd0);
    chk("full_count", 80'(acc), 80'(DEPTH + 1));
    drain();

    // privilege check
    priv_case(2'b01, 16'h0D12, 16'h0050, PRIV);
    priv_case(2'b00, 16'h0D12, 16'h0051, 1'b0);
    priv_case(2'b01, 16'hE000, 16'h0052, PRIV);
    ifc.mode = 2'b00;

    // flush with half an LI buffered
    push(16'hF500, 16'h0060);
    ifc.flush = 1'b1;
    cyc();
    ifc.flush = 1'b0;
    chk("flush_valid", 80'(ifc.out_valid), 80'd0);
    chk("flush_ready", 80'(ifc.in_ready), 80'd1);
    push(16'h2312, 16'h0061);
    cyc();
    chk("xor_alu", 80'({ifc.out_alu_op, ifc.out_dst, ifc.out_p0, ifc.out_p1}), 80'({3'd2, 4'd3, 4'd1, 4'd2}));
    drain();

    // random traffic with stalls, flushes and user mode
    ifc.mode = 2'b01;
    for (int i = 0; i < 500; i++) begin
      ifc.in_valid  = ($urandom % 4) != 0;
      ifc.in_instr  = 16'($urandom);
      ifc.in_pc     = 16'($urandom);
      ifc.out_ready = ($urandom % 3) != 0;
      ifc.flush     = ($urandom % 50) == 0;
      cyc();
    end
    ifc.in_valid = 1'b0;
    ifc.flush = 1'b1;
    cyc();
    ifc.flush = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
